// File: rtl/uart_alu_frame_ctrl_pkg.sv
// Shared definitions for the UART-to-ALU frame controller: one-cold state
// encodings and helpers for sizing the byte-lane index and timeout timer.
package uart_alu_frame_ctrl_pkg;

  localparam int unsigned STATE_W = 6;

  // One-cold encodings: exactly one bit low per state.
  typedef enum logic [STATE_W-1:0] {
    LOAD_A  = 6'b111110,
    LOAD_B  = 6'b111101,
    LOAD_OP = 6'b111011,
    CAPTURE = 6'b110111,
    SEND    = 6'b101111,
    WAIT    = 6'b011111
  } state_e;

  // Width of an index over n byte lanes (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a timer that must hold values 0 .. cycles-1 (at least one bit).
  function automatic int unsigned timer_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_assembler.sv
// Multi-byte operand register written one byte lane at a time, LSB lane
// first, with its own lane index and a "current lane is the last" flag.
module uart_byte_assembler
  import uart_alu_frame_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BYTES      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic                        restart,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH*BYTES-1:0] word,
  output logic                        last_c
);

  localparam int unsigned IW = idx_w(BYTES);

  logic [IW-1:0] idx_q;

  assign last_c = (idx_q == IW'(BYTES - 1));

  // Lane index: advance per written byte, wrap after the last lane, or restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else if (wr_en) begin
      idx_q <= last_c ? '0 : IW'(idx_q + IW'(1));
    end else if (restart) begin
      idx_q <= '0;
    end
  end

  // Lane write: only the addressed lane changes, others keep their old bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (idx_q == IW'(i)) word[i*DATA_WIDTH +: DATA_WIDTH] <= din;
      end
    end
  end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// UART-to-ALU frame controller: assembles operands A/B and an opcode from
// received bytes, captures the ALU result and sends it LSB byte first with a
// start/done handshake per byte. Inter-byte timeout discards partial frames.
// Optional build macro UART_ALU_CHECKSUM_EN appends an XOR checksum byte.
module uart_alu_frame_ctrl
  import uart_alu_frame_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OPERAND_BYTES  = 2,
  parameter int unsigned OP_WIDTH       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                rx_done,
  input  logic [DATA_WIDTH-1:0]               rx_data,
  input  logic                                tx_done,
  output logic                                tx_start,
  output logic [DATA_WIDTH-1:0]               tx_data,
  output logic [DATA_WIDTH*OPERAND_BYTES-1:0] alu_a,
  output logic [DATA_WIDTH*OPERAND_BYTES-1:0] alu_b,
  output logic [OP_WIDTH-1:0]                 alu_op,
  input  logic [DATA_WIDTH*OPERAND_BYTES-1:0] alu_result,
  output logic                                busy,
  output logic                                frame_error,
  output logic                                rx_overrun
);

  localparam int unsigned W = DATA_WIDTH * OPERAND_BYTES;
`ifdef UART_ALU_CHECKSUM_EN
  localparam int unsigned TX_BYTES = OPERAND_BYTES + 1;
`else
  localparam int unsigned TX_BYTES = OPERAND_BYTES;
`endif
  localparam int unsigned TXW   = idx_w(TX_BYTES);
  localparam int unsigned TW    = timer_w(TIMEOUT_CYCLES);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

  state_e                  state_q, state_d;
  logic [TXW-1:0]          tx_idx_q, tx_idx_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [W-1:0]            result_q, result_d;
  logic                    busy_d, tx_start_d, frame_error_d, rx_overrun_d;
  logic [DATA_WIDTH-1:0]   tx_data_d;
  logic [OP_WIDTH-1:0]     alu_op_d;
  logic                    wr_a_c, wr_b_c, restart_c;
  logic                    last_a_c, last_b_c, in_load_c, expire_c;

  // Transmit byte i of a result word; index OPERAND_BYTES is the checksum.
  function automatic logic [DATA_WIDTH-1:0] lane(input logic [W-1:0] word,
                                                 input logic [TXW-1:0] i);
    logic [DATA_WIDTH-1:0] b;
`ifdef UART_ALU_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
    sum = '0;
`endif
    b = '0;
    for (int unsigned k = 0; k < OPERAND_BYTES; k++) begin
      if (i == TXW'(k)) b = word[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef UART_ALU_CHECKSUM_EN
      sum = sum ^ word[k*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
`ifdef UART_ALU_CHECKSUM_EN
    if (i == TXW'(OPERAND_BYTES)) b = sum;
`endif
    return b;
  endfunction

  uart_byte_assembler #(.DATA_WIDTH(DATA_WIDTH), .BYTES(OPERAND_BYTES)) u_asm_a (
    .clk(clk), .reset(reset), .wr_en(wr_a_c), .restart(restart_c),
    .din(rx_data), .word(alu_a), .last_c(last_a_c)
  );

  uart_byte_assembler #(.DATA_WIDTH(DATA_WIDTH), .BYTES(OPERAND_BYTES)) u_asm_b (
    .clk(clk), .reset(reset), .wr_en(wr_b_c), .restart(restart_c),
    .din(rx_data), .word(alu_b), .last_c(last_b_c)
  );

  assign in_load_c = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire_c  = TO_EN && busy && in_load_c && !rx_done &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    tx_idx_d      = tx_idx_q;
    timer_d       = timer_q;
    result_d      = result_q;
    busy_d        = busy;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data;
    frame_error_d = 1'b0;
    rx_overrun_d  = 1'b0;
    alu_op_d      = alu_op;
    wr_a_c        = 1'b0;
    wr_b_c        = 1'b0;
    restart_c     = 1'b0;

    if (TO_EN && busy && in_load_c) timer_d = TW'(timer_q + TW'(1));

    unique case (state_q)
      LOAD_A: if (rx_done) begin
        wr_a_c  = 1'b1;
        busy_d  = 1'b1;
        timer_d = '0;
        if (last_a_c) state_d = LOAD_B;
      end
      LOAD_B: if (rx_done) begin
        wr_b_c  = 1'b1;
        timer_d = '0;
        if (last_b_c) state_d = LOAD_OP;
      end
      LOAD_OP: if (rx_done) begin
        alu_op_d = rx_data[OP_WIDTH-1:0];
        timer_d  = '0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        // Load byte 0 now so tx_data is valid in the same cycle as tx_start.
        result_d   = alu_result;
        tx_idx_d   = '0;
        tx_data_d  = lane(alu_result, '0);
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: if (tx_done) begin
        if (tx_idx_q == TXW'(TX_BYTES - 1)) begin
          tx_idx_d = '0;
          busy_d   = 1'b0;
          state_d  = LOAD_A;
        end else begin
          tx_idx_d   = TXW'(tx_idx_q + TXW'(1));
          tx_data_d  = lane(result_q, TXW'(tx_idx_q + TXW'(1)));
          tx_start_d = 1'b1;
          state_d    = SEND;
        end
      end
      default: state_d = LOAD_A;
    endcase

    if (rx_done && !in_load_c) rx_overrun_d = 1'b1;

    if (expire_c) begin
      state_d       = LOAD_A;
      busy_d        = 1'b0;
      timer_d       = '0;
      frame_error_d = 1'b1;
      restart_c     = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD_A;
      tx_idx_q    <= '0;
      timer_q     <= '0;
      result_q    <= '0;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      frame_error <= 1'b0;
      rx_overrun  <= 1'b0;
      alu_op      <= '0;
    end else begin
      state_q     <= state_d;
      tx_idx_q    <= tx_idx_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      busy        <= busy_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      frame_error <= frame_error_d;
      rx_overrun  <= rx_overrun_d;
      alu_op      <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Scoreboard bench for uart_alu_frame_ctrl: frames are modelled as byte
// lists, expected transmit bytes are queued at stimulus time and popped by a
// monitor that also plays the UART transmitter handshake.
module tb_uart_alu_frame_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned NB  = 2;
  localparam int unsigned OPW = 6;
  localparam int unsigned TO  = 20;
  localparam int unsigned W   = DW * NB;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           rx_done = 1'b0;
  logic [DW-1:0]  rx_data = '0;
  logic           tx_done = 1'b0;
  logic           tx_start;
  logic [DW-1:0]  tx_data;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [OPW-1:0] alu_op;
  logic           busy, frame_error, rx_overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor / transmitter-model state.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held = '0;
  bit  pend = 0;
  bit  in_frame = 0;
  bit  manual_txd = 0;
  int  cnt = 0;
  int  tx_delay = 0;
  int  first_start_cyc = 0;
  int  last_rx_cyc = 0;
  int  fe_cnt = 0, fe_exp = 0;
  int  ov_cnt = 0, ov_exp = 0;

  uart_alu_frame_ctrl #(
    .DATA_WIDTH(DW), .OPERAND_BYTES(NB), .OP_WIDTH(OPW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .frame_error(frame_error), .rx_overrun(rx_overrun)
  );

  // External ALU behaviour: the low two opcode bits select the operation.
  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [OPW-1:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts pulses, checks each transmitted byte, answers with tx_done.
  always @(negedge clk) begin
    tx_done = manual_txd;
    if (frame_error) fe_cnt++;
    if (rx_overrun) ov_cnt++;
    if (!busy) in_frame = 0;
    if (!reset) begin
      pend = 0;
    end else if (pend) begin
      if (cnt == 0) begin
        check("tx_hold", 32'(tx_data), 32'(held));
        tx_done = 1'b1;
        pend = 0;
      end else begin
        cnt--;
      end
    end
    if (tx_start) begin
      check("no_early_start", 32'(pend), 32'd0);
      if (!in_frame) first_start_cyc = cyc;
      in_frame = 1;
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      held = tx_data;
      pend = 1;
      cnt  = tx_delay;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Expected transmit bytes for a frame, derived from the operands alone.
  task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic [DW-1:0] op);
    logic [W-1:0]  r;
    logic [DW-1:0] sum;
    r = alu_model(a, b, op[OPW-1:0]);
    sum = '0;
    for (int i = 0; i < int'(NB); i++) begin
      exp_q.push_back(r[i*DW +: DW]);
      sum = sum ^ r[i*DW +: DW];
    end
`ifdef UART_ALU_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  // Sends A, B (LSB first) and the opcode; gap<0 picks random short gaps.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [DW-1:0] op, input int gap);
    logic [DW-1:0] bytes[$];
    for (int i = 0; i < int'(NB); i++) bytes.push_back(a[i*DW +: DW]);
    for (int i = 0; i < int'(NB); i++) bytes.push_back(b[i*DW +: DW]);
    for (int i = 0; i < bytes.size(); i++) begin
      idle((gap < 0) ? int'($urandom_range(0, 4)) : gap);
      send_byte(bytes[i]);
      if (i == 0) check("busy_set", 32'(busy), 32'd1);
    end
    idle((gap < 0) ? int'($urandom_range(0, 4)) : gap);
    push_expect(a, b, op);
    send_byte(op);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_tx_start(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_regs(input logic [W-1:0] a, input logic [W-1:0] b, input logic [DW-1:0] op);
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_op", 32'(alu_op), 32'(op[OPW-1:0]));
  endtask

  initial begin
    logic [W-1:0]  a, b;
    logic [DW-1:0] op;

    // Reset values.
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_flags", 32'({busy, frame_error, rx_overrun}), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // Nominal frame.
    tx_delay = 2;
    send_frame(16'h1234, 16'h0101, 8'h20, 0);
    wait_idle("nominal_done");
    check("nominal_latency", 32'(first_start_cyc - last_rx_cyc), 32'd2);
    check_regs(16'h1234, 16'h0101, 8'h20);

    // Slow transmitter: tx_data must hold and no early second start.
    tx_delay = 50;
    a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
    send_frame(a, b, op, 1);
    wait_idle("slow_done");
    check("slow_latency", 32'(first_start_cyc - last_rx_cyc), 32'd2);
    check_regs(a, b, op);

    // Timeout after a single byte.
    tx_delay = 1;
    send_byte(8'h34);
    idle(25);
    fe_exp++;
    check("timeout_fe", 32'(fe_cnt), 32'(fe_exp));
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_keep_a", 32'(alu_a[DW-1:0]), 32'h34);
    a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
    send_frame(a, b, op, 0);
    wait_idle("after_timeout_done");
    check_regs(a, b, op);

    // Every byte arrives exactly in the expiry cycle: no error.
    a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
    send_frame(a, b, op, TO - 2);
    wait_idle("edge_timeout_done");
    check("edge_timeout_fe", 32'(fe_cnt), 32'(fe_exp));
    check_regs(a, b, op);

    // Byte received while waiting for tx_done is dropped.
    tx_delay = 10;
    a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
    send_frame(a, b, op, 0);
    wait_tx_start("overrun_start");
    send_byte(8'hAA);
    ov_exp++;
    wait_idle("overrun_done");
    check("overrun_cnt", 32'(ov_cnt), 32'(ov_exp));
    check_regs(a, b, op);

    // tx_done while loading B is ignored.
    tx_delay = 0;
    a = 16'h0F0F; b = 16'h1111; op = 8'h01;
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    @(posedge clk); #2 manual_txd = 1'b1;
    @(posedge clk); #2 manual_txd = 1'b0;
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    push_expect(a, b, op);
    send_byte(op);
    wait_idle("stray_txd_done");
    check_regs(a, b, op);

    // Asynchronous reset while waiting for the first byte's tx_done.
    tx_delay = 40;
    send_frame(16'h2222, 16'h3333, 8'h00, 0);
    wait_tx_start("reset_start");
    idle(3);
    #3 reset = 1'b0;
    #1;
    check("arst_tx_start", 32'(tx_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_alu_a", 32'(alu_a), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    exp_q.delete();
    idle(2);
    reset = 1'b1;
    idle(2);
    tx_delay = 3;
    send_frame(16'h1234, 16'h0101, 8'h20, 0);
    wait_idle("post_reset_done");
    check_regs(16'h1234, 16'h0101, 8'h20);

    // Randomised frames.
    for (int n = 0; n < 8; n++) begin
      tx_delay = int'($urandom_range(0, 4));
      a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
      send_frame(a, b, op, -1);
      wait_idle("rand_done");
      check_regs(a, b, op);
    end

    idle(30);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_fe", 32'(fe_cnt), 32'(fe_exp));
    check("final_ov", 32'(ov_cnt), 32'(ov_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
Parametrised successor to the single-byte UART-to-ALU interface FSM. It assembles multi-byte operands A and B and an opcode byte from the UART receiver, and presents them to an external ALU. It then captures the ALU result and serialises it, least-significant byte first, to the UART transmitter with a per-byte start/done handshake. An inter-byte timeout discards partial frames, and overruns are flagged. It sits between uart_rx/uart_tx and the ALU in the top level.

Parameters:
DATA_WIDTH, 8, UART byte width
OPERAND_BYTES, 2, bytes per operand and per result (≥1); operand width W = DATA_WIDTH*OPERAND_BYTES
OP_WIDTH, 6, opcode width (≤ DATA_WIDTH); low OP_WIDTH bits of the opcode byte are used
TIMEOUT_CYCLES, 100000, max idle clocks between bytes of one frame; 0 disables the timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_done  in  1  one-cycle pulse, byte valid on rx_data
rx_data  in  DATA_WIDTH  received byte
tx_done  in  1  one-cycle pulse, transmitter finished current byte
tx_start  out  1  one-cycle pulse, start transmitting tx_data
tx_data  out  DATA_WIDTH  byte to transmit (registered)
alu_a  out  W  operand A (registered)
alu_b  out  W  operand B (registered)
alu_op  out  OP_WIDTH  opcode (registered)
alu_result  in  W  combinational ALU result
busy  out  1  high from first byte of A until last result byte done
frame_error  out  1  one-cycle pulse on timeout discard
rx_overrun  out  1  one-cycle pulse when rx_done is dropped (while in CAPTURE/SEND/WAIT)

Behaviour:
- Reset (async assert, sync release): state=LOAD_A; byte_idx=0; timer=0; all outputs 0.
- States: LOAD_A, LOAD_B, LOAD_OP, CAPTURE, SEND, WAIT.
- LOAD_A/LOAD_B, on rx_done:
  - write rx_data into byte lane byte_idx of the operand register (byte 0 = LSB);
  - when byte_idx==OPERAND_BYTES-1, clear byte_idx and advance (A→B, B→OP); otherwise increment byte_idx.
  - A lane written this frame updates alu_a/alu_b on the next edge; lanes not yet written keep their previous values.
- LOAD_OP: on rx_done, alu_op <= rx_data[OP_WIDTH-1:0], then → CAPTURE.
- CAPTURE: exactly one cycle. result_q <= alu_result (operands are stable here), then → SEND with byte_idx=0.
- SEND: exactly one cycle. tx_start=1; tx_data <= result_q byte byte_idx, registered so it is valid in the same cycle as tx_start; then → WAIT.
- WAIT:
  - tx_done is sampled only in this state; tx_done seen in any other state is ignored.
  - tx_data holds until tx_done.
  - On tx_done: if byte_idx==OPERAND_BYTES-1 → LOAD_A, byte_idx=0, busy drops next cycle; otherwise byte_idx++ → SEND.
- Latency: opcode rx_done at edge N → CAPTURE in cycle N+1 → first tx_start high in cycle N+2.
- busy: set on the first accepted byte of A; cleared on return to LOAD_A.
- Timeout:
  - timer counts only while busy and in LOAD_A/LOAD_B/LOAD_OP; it clears on every accepted rx_done.
  - When timer reaches TIMEOUT_CYCLES: pulse frame_error, → LOAD_A, byte_idx=0, busy=0. alu_a/alu_b/alu_op retain their values.
  - rx_done in the same cycle as expiry: the byte is accepted and the timer clears (no error).
- rx_done during CAPTURE/SEND/WAIT: byte dropped, rx_overrun pulses, state unaffected.
- OPERAND_BYTES=1 reproduces the single-byte A/B/OP/transmit sequence.
- Reset mid-frame or mid-transmission: immediate return to reset values; tx_start deasserts asynchronously.

Optional Feature:
UART_ALU_CHECKSUM_EN.
- Defined: after the last result byte, one extra SEND/WAIT pass transmits the XOR of all result bytes. busy is held through it.
- Undefined: exactly OPERAND_BYTES bytes are transmitted and no checksum logic exists.

Decomposition:
- Shared include/package uart_alu_defs: state encodings (one-cold, STATE_W=6), byte-lane index width function (clog2), timer width.
- One natural sub-module: uart_byte_assembler, parametrised shift/lane-write register with an index counter and a "last byte" flag; instantiated once each for A and B.

Test Plan:
All cases use OPERAND_BYTES=2 and a bench ALU model result = A+B unless noted.
1. Nominal frame: rx 0x34, 0x12, 0x01, 0x01, op 0x20 → alu_a=0x1234, alu_b=0x0101; tx_start twice with tx_data 0x35 then 0x13; busy falls after the second tx_done.
2. Latency/hold: opcode rx_done at cycle N → tx_start at N+2; tx_data stable until tx_done is delayed 50 cycles; no second tx_start before tx_done.
3. Timeout: TIMEOUT_CYCLES=20, send 0x34 then idle 20 cycles → frame_error pulse once, state LOAD_A; next 5-byte frame transmits correctly. Also rx_done exactly at expiry → no error.
4. Overrun/spurious handshakes: rx_done during WAIT → rx_overrun pulse, output bytes unchanged; tx_done in LOAD_B → ignored.
5. Reset: assert reset during WAIT of the first result byte → tx_start=0, busy=0, alu_a=0 immediately; a clean frame afterwards works.
6. UART_ALU_CHECKSUM_EN defined, result 0x1335 → tx bytes 0x35, 0x13, 0x26.
